// File: rtl/regfile_pkg.sv
// Shared constants and types for the architectural register file.
package regfile_pkg;

    localparam int        REG_WIDTH  = 64;
    localparam int        NUM_REGS   = 32;
    localparam int        REG_ADDR_W = 5;
    localparam logic [4:0] ZERO_REG  = 5'd31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_WIDTH-1:0]  reg_data_t;

endpackage

// File: rtl/regfile_if.sv
// Write-port and read-port bundle between writeback/operand-select and the register file.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
);

    logic             RegWrite;
    reg_addr_t        WriteRegister;
    logic [WIDTH-1:0] WriteData;
    reg_addr_t        ReadRegister1;
    reg_addr_t        ReadRegister2;
    logic [WIDTH-1:0] ReadData1;
    logic [WIDTH-1:0] ReadData2;

    // Pipeline side: issues writes and read addresses, consumes read data.
    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2
    );

    // Register file side.
    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2
    );

endinterface

// File: rtl/regfile_dec5_32.sv
// 5-to-32 one-hot write-enable decoder, built as a 2->4 stage (gated by the
// enable) crossed with a 3->8 stage.
module regfile_dec5_32
    import regfile_pkg::*;
(
    input  logic                en_i,
    input  reg_addr_t           addr_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    logic [3:0] hi_oh;
    logic [7:0] lo_oh;

    // Upper two address bits select a bank of eight; the enable gates here.
    always_comb begin
        hi_oh = '0;
        if (en_i) begin
            hi_oh[addr_i[4:3]] = 1'b1;
        end
    end

    // Lower three address bits select an entry within the bank.
    always_comb begin
        lo_oh = '0;
        lo_oh[addr_i[2:0]] = 1'b1;
    end

    // Combine bank and entry selects into the final one-hot vector.
    always_comb begin
        onehot_o = '0;
        for (int h = 0; h < 4; h++) begin
            for (int l = 0; l < 8; l++) begin
                onehot_o[h*8 + l] = hi_oh[h] & lo_oh[l];
            end
        end
    end

endmodule

// File: rtl/regfile.sv
// Architectural register file: 31 real 64-bit registers plus a hardwired-zero
// entry, one synchronous write port and two combinational read ports.
// The top index (ZERO_REG = NREGS-1) has no storage.
module regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int NREGS = NUM_REGS
)(
    input  logic     clk,
    input  logic     reset,
    regfile_if.slave bus
);

    logic [NREGS-2:0] wr_en;
    logic             dec_unused_zero;
    logic [WIDTH-1:0] regs_q [NREGS-1];
    logic [WIDTH-1:0] mux_in [NREGS];

    // The enable for the zero register is produced but deliberately dropped.
    regfile_dec5_32 u_dec (
        .en_i     (bus.RegWrite),
        .addr_i   (bus.WriteRegister),
        .onehot_o ({dec_unused_zero, wr_en})
    );

    for (genvar g = 0; g < NREGS - 1; g++) begin : g_reg
        logic [WIDTH-1:0] reg_d;
        logic [WIDTH-1:0] reg_q;

        // Reset wins over a write; otherwise load on enable, else hold.
        always_comb begin
            reg_d = reg_q;
            if (reset) begin
                reg_d = '0;
            end else if (wr_en[g]) begin
                reg_d = bus.WriteData;
            end
        end

        // Register state update.
        always_ff @(posedge clk) begin
            reg_q <= reg_d;
        end

        assign regs_q[g] = reg_q;
    end

    // Read-mux inputs: real registers, with the zero entry tied to 0.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            mux_in[i] = '0;
        end
        for (int i = 0; i < NREGS - 1; i++) begin
            mux_in[i] = regs_q[i];
        end
    end

    // Reads see pre-edge state; there is no write-to-read bypass.
    assign bus.ReadData1 = mux_in[bus.ReadRegister1];
    assign bus.ReadData2 = mux_in[bus.ReadRegister2];

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile with a queue-based scoreboard and negedge monitor.
module tb_regfile;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic rd_vld;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    regfile_if #(.WIDTH(REG_WIDTH)) bus ();

    regfile #(.WIDTH(REG_WIDTH), .NREGS(NUM_REGS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [63:0] e1;
        logic [63:0] e2;
    } exp_t;

    exp_t sb[$];

    // One clock cycle of stimulus; optionally queue the expected read data.
    task automatic cyc(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic chk, input logic [63:0] e1, input logic [63:0] e2,
                       input string nm);
        exp_t e;
        reset             = rst;
        bus.RegWrite      = we;
        bus.WriteRegister = wa;
        bus.WriteData     = wd;
        bus.ReadRegister1 = r1;
        bus.ReadRegister2 = r2;
        rd_vld            = chk;
        if (chk) begin
            e.name = nm;
            e.e1   = e1;
            e.e2   = e2;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] wa, input logic [63:0] wd);
        cyc(1'b0, 1'b1, wa, wd, 5'd0, 5'd0, 1'b0, 64'h0, 64'h0, "");
    endtask

    task automatic rd(input logic [4:0] r1, input logic [4:0] r2,
                      input logic [63:0] e1, input logic [63:0] e2, input string nm);
        cyc(1'b0, 1'b0, 5'd0, 64'h0, r1, r2, 1'b1, e1, e2, nm);
    endtask

    // Monitor: mid-cycle, compare both read ports against the queued expectation.
    always @(negedge clk) begin
        if (rd_vld === 1'b1) begin
            if (sb.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL sb_empty: read presented with no expectation queued");
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_run++;
                if (bus.ReadData1 !== e.e1) begin
                    n_fail++;
                    $display("FAIL %s port1: got %h expected %h", e.name, bus.ReadData1, e.e1);
                end
                n_run++;
                if (bus.ReadData2 !== e.e2) begin
                    n_fail++;
                    $display("FAIL %s port2: got %h expected %h", e.name, bus.ReadData2, e.e2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        rd_vld            = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = '0;
        bus.WriteData     = '0;
        bus.ReadRegister1 = '0;
        bus.ReadRegister2 = '0;
        @(posedge clk);
        #1;

        // Every address reads zero after reset.
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(31 - a), 64'h0, 64'h0, "reset_all");
        end

        // Basic write and readback on both ports; neighbours unaffected.
        wr(5'd3, 64'h1234_5678_9ABC_DEF0);
        rd(5'd3, 5'd3, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, "x3_both");
        rd(5'd2, 5'd4, 64'h0, 64'h0, "x2_x4_zero");

        // Writes to the zero register are discarded.
        wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(5'd31, 5'd31, 64'h0, 64'h0, "x31_zero");
        for (int a = 0; a < 31; a++) begin
            rd(5'(a), 5'd31, (a == 3) ? 64'h1234_5678_9ABC_DEF0 : 64'h0, 64'h0, "after_x31_write");
        end

        // No bypass: same-cycle read sees old value, new value after the edge.
        cyc(1'b0, 1'b1, 5'd7, 64'hA5A5, 5'd7, 5'd7, 1'b1, 64'h0, 64'h0, "x7_pre_edge");
        rd(5'd7, 5'd7, 64'hA5A5, 64'hA5A5, "x7_post_edge");

        // RegWrite=0 leaves the addressed register unchanged.
        wr(5'd9, 64'h99);
        cyc(1'b0, 1'b0, 5'd9, 64'hDEAD, 5'd9, 5'd9, 1'b1, 64'h99, 64'h99, "hold_same_cycle");
        rd(5'd9, 5'd9, 64'h99, 64'h99, "hold_after");

        // Fill every real register with its index, read back crosswise.
        for (int i = 0; i < 31; i++) begin
            wr(5'(i), 64'(i));
        end
        for (int i = 0; i < 31; i++) begin
            rd(5'(i), 5'(30 - i), 64'(i), 64'(30 - i), "index_fill");
        end

        // Reset beats a simultaneous write; contents before the edge still visible.
        wr(5'd5, 64'h55);
        cyc(1'b1, 1'b1, 5'd6, 64'h66, 5'd5, 5'd6, 1'b1, 64'h55, 64'h6, "reset_pre_edge");
        rd(5'd5, 5'd6, 64'h0, 64'h0, "reset_vs_write");
        rd(5'd30, 5'd0, 64'h0, 64'h0, "reset_clears_all");

        cyc(1'b0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 1'b0, 64'h0, 64'h0, "");
        for (int k = 0; k < 10 && sb.size() != 0; k++) begin
            @(posedge clk);
        end
        n_run++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile.md
# regfile

Architectural register file for the 64-bit datapath: 32 entries × 64 bits, one synchronous write port and two combinational read ports. It sits between writeback and the operand-select stage. Its two read outputs feed the ALU-input and store-data multiplexers, and the write port is driven by the writeback mux. Register 31 is hardwired to zero.

## Interface
- WIDTH, 64, data width of every register
- NREGS, 32, number of registers; address width is log2(NREGS) = 5
- ZERO_REG, 31, index that always reads 0 and ignores writes
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk
- RegWrite  input  1  write enable for the current cycle
- WriteRegister  input  5  destination index
- WriteData  input  WIDTH  value to store
- ReadRegister1  input  5  port-1 source index
- ReadRegister2  input  5  port-2 source index
- ReadData1  output  WIDTH  contents of ReadRegister1
- ReadData2  output  WIDTH  contents of ReadRegister2

## Operation
- Storage: NREGS−1 real 64-bit registers. ZERO_REG has no flops and is a constant 0.
- Reset: on a clk edge with reset=1, all real registers load 0, regardless of RegWrite.
  - Reset has priority over a write in the same cycle.
  - Immediately after reset, ReadData1 = ReadData2 = 0 for every address.
- Write: on a clk edge with reset=0 and RegWrite=1, register[WriteRegister] ← WriteData.
  - Exactly one register changes; all others hold.
  - A write to ZERO_REG is discarded.
- Hold: with RegWrite=0, no register changes.
- Read:
  - ReadDataN = register[ReadRegisterN] combinationally; no clock is involved.
  - ReadRegisterN = ZERO_REG always yields 0.
  - Both ports may address the same register, and both return the same value.
- No write-to-read bypass. During the write cycle, a read of the register being written returns the pre-edge (old) value. The new value appears after the edge.
- The write address is fully decoded to one-hot enables gated by RegWrite. Undecoded or X addresses are not a legal use.

## Timing
- Write latency: 1 edge. The value is visible on the read ports in the cycle after the edge where RegWrite=1.
- Read latency: 0 cycles, combinational from ReadRegisterN and register state. The path must settle within one clk period, through the decoder-free mux tree only.
- Reset latency: 1 edge. Reset asserted mid-sequence clears all state on the next edge. A write presented in that cycle is lost.
- Output values during reset follow the register contents. They are 0 from the first reset edge onward.

## Structure
- regfile_pkg:
  - REG_WIDTH = 64, NUM_REGS = 32, REG_ADDR_W = 5, ZERO_REG = 5'd31
  - type reg_addr_t (logic [4:0]) and reg_data_t (logic [63:0])
- One sub-module, regfile_dec5_32: a 5→32 one-hot decoder with enable (RegWrite).
  - Output bit ZERO_REG is left unconnected.
  - Built from 3→8 and 2→4 decode stages, in keeping with the structural mux/decoder library.
- Read ports: one 32:1 × WIDTH mux per port from the existing mux library. The data input at index ZERO_REG is tied to 0.
- Registers: a generate loop over indices 0..30 of D flip-flops with enable.
  - Next-state = reset ? 0 : (en ? WriteData : q).

## Test plan
- Reset, then read all 32 addresses on both ports → every read is 64'h0.
- Write X3 ← 64'h1234_5678_9ABC_DEF0 with RegWrite=1, then read X3 on port 1 and X3 on port 2 next cycle → both read 64'h1234_5678_9ABC_DEF0; X2 and X4 still 0.
- Write X31 ← 64'hFFFF_FFFF_FFFF_FFFF, then read X31 → 0. Also read X0–X30 → unchanged.
- In the same cycle, write X7 ← 64'hA5A5 and read X7 → the pre-edge read is the old value (0). The post-edge read is 64'hA5A5.
- Present WriteRegister=9, WriteData=64'hDEAD with RegWrite=0 → X9 stays at its prior value. Write all X0–X30 with value = index, then read port1 = i and port2 = 30−i for i = 0..30 → each port returns its own index.
- With X5 = 64'h55, assert reset together with RegWrite=1, WriteRegister=6, WriteData=64'h66 → on the next cycle X5 = 0 and X6 = 0.
